pwm_capture_decoder: RTL
========================

PWM_CAPTURE_DECODER -- requirements
Module: pwm_capture_decoder

Interface
REQ-001 Parameter TIMEOUT, 22'h3FFFFF, idle cycles with no PWM_IN edge before declaring signal loss.
REQ-002 Parameter LN_SPLIT, 21'h20DCC, WIDTH below this classifies as LEFT.
REQ-003 Parameter NR_SPLIT, 21'h2445E, WIDTH at or above this classifies as RIGHT; otherwise NEUTRAL.
REQ-004 CLK  input  1  system clock; all logic on posedge.
REQ-005 RESET  input  1  reset; synchronous, active-low (RESET==0 resets on CLK edge).
REQ-006 PWM_IN  input  1  asynchronous servo PWM waveform to measure.
REQ-007 WIDTH  output  21  last measured high time, CLK cycles.
REQ-008 PERIOD  output  22  last measured rising-to-rising period, CLK cycles.
REQ-009 VALID  output  1  one-cycle strobe: new WIDTH/PERIOD/POS pair published.
REQ-010 POS  output  3  one-hot class of WIDTH: 100 LEFT, 010 NEUTRAL, 001 RIGHT, 000 none.
REQ-011 LOSS  output  2  00 ok, 01 stuck low, 10 stuck high; held until next valid measurement.

Function
REQ-012 PWM_IN SHALL pass a 2-flop synchronizer; edge detect compares sync output to its previous value, so an edge is detected 3 CLK edges after the input transition.
REQ-013 States: SYNC, WAIT_RISE, HIGH, LOW.
REQ-014 SYNC: wait for synchronized level 0, then -> WAIT_RISE; no measurement published.
REQ-015 WAIT_RISE: on rising edge clear both counters to 1 -> HIGH.
REQ-016 HIGH: both counters +1 per cycle; on falling edge latch high counter into internal width register -> LOW.
REQ-017 LOW: period counter +1 per cycle; on rising edge, in that same cycle publish WIDTH=latched width, PERIOD=period counter, POS, VALID=1, LOSS=00, reload both counters to 1, stay measuring -> HIGH.
REQ-018 A pulse high for exactly K synchronized samples SHALL yield WIDTH=K; a period of P samples SHALL yield PERIOD=P.
REQ-019 First measurement SHALL require one full rise-fall-rise sequence; no VALID from a partial first pulse.
REQ-020 Counters SHALL saturate at all-ones, never wrap.
REQ-021 POS SHALL be computed from the value being published and registered with it.
REQ-022 If time since last edge reaches TIMEOUT in HIGH or LOW (or WAIT_RISE), set LOSS to 10 if synchronized level is 1, else 01; POS<=000; no VALID; -> SYNC.
REQ-023 WIDTH and PERIOD SHALL hold their last published value during loss.
REQ-024 VALID SHALL never be high on two consecutive cycles.
REQ-025 Glitches shorter than one CLK period are not filtered beyond the synchronizer; each detected edge is acted on.

Reset
REQ-026 While RESET==0 at a CLK edge: state SYNC, counters 0, WIDTH=0, PERIOD=0, VALID=0, POS=000, LOSS=00, synchronizer flops 0.
REQ-027 RESET asserted mid-pulse SHALL discard the partial measurement; after release the first VALID follows a fresh full period.

Verification
REQ-028 Reset, then PWM_IN period 22'h1FFFFE with high 21'h1F26A -> first VALID after second rise, WIDTH=21'h1F26A, PERIOD=22'h1FFFFE, POS=100.
REQ-029 High 21'h2292C, same period -> POS=010; high 21'h25FEE -> POS=001; boundary high=NR_SPLIT -> POS=001, NR_SPLIT-1 -> 010.
REQ-030 PWM_IN held 1 for TIMEOUT+10 cycles after a valid stream -> LOSS=10, POS=000, no VALID, WIDTH/PERIOD unchanged; resume stream -> LOSS=00 at next VALID.
REQ-031 PWM_IN held 0 from reset -> LOSS=01 after TIMEOUT cycles, VALID never asserted.
REQ-032 RESET pulsed low for 1 cycle during HIGH -> all outputs zero, next VALID only after complete new period, values exact.
REQ-033 Pulse width 5, period 12 repeated -> WIDTH=5, PERIOD=12, VALID every 12 cycles, single-cycle strobe.

Source files
------------

// File: rtl/pwm_capture_decoder.sv
// pwm_capture_decoder: measures the high time and the rising-to-rising period
// of an asynchronous servo PWM input, classifies the high time as
// LEFT / NEUTRAL / RIGHT, and reports stuck-low / stuck-high signal loss.
module pwm_capture_decoder #(
  parameter logic [21:0] TIMEOUT  = 22'h3FFFFF,
  parameter logic [20:0] LN_SPLIT = 21'h20DCC,
  parameter logic [20:0] NR_SPLIT = 21'h2445E
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PWM_IN,
  output logic [20:0] WIDTH,
  output logic [21:0] PERIOD,
  output logic        VALID,
  output logic [2:0]  POS,
  output logic [1:0]  LOSS
);

  typedef enum logic [1:0] {S_SYNC, S_WAIT_RISE, S_HIGH, S_LOW} state_t;

  localparam logic [2:0] POS_LEFT    = 3'b100;
  localparam logic [2:0] POS_NEUTRAL = 3'b010;
  localparam logic [2:0] POS_RIGHT   = 3'b001;

  // One-hot class of a width value.
  function automatic logic [2:0] classify(input logic [20:0] width);
    if (width < LN_SPLIT)       return POS_LEFT;
    else if (width >= NR_SPLIT) return POS_RIGHT;
    else                        return POS_NEUTRAL;
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync_prev;
  logic [1:0]  r_sync_vld;
  logic [21:0] r_idle;
  logic [20:0] r_hcnt;
  logic [21:0] r_pcnt;
  logic [20:0] r_width_lat;
  logic [20:0] r_width;
  logic [21:0] r_period;
  logic        r_valid;
  logic [2:0]  r_pos;
  logic [1:0]  r_loss;
  logic        w_rise;
  logic        w_fall;
  logic        w_timeout;
  logic        w_start;
  logic        w_latch;
  logic        w_publish;
  logic        w_loss;

  // Two-flop synchronizer plus previous-sample flop for edge detection.
  // r_sync_vld marks when r_sync2 holds a real post-reset sample, so the
  // reset-zero pipeline is never mistaken for a low level (and a following
  // rise) while the input is actually high.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!RESET) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_sync_vld  <= 2'b00;
    end else begin
      r_sync1     <= PWM_IN;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_sync_vld  <= {r_sync_vld[0], 1'b1};
    end
  end

  assign w_rise    = r_sync2 & ~r_sync_prev;
  assign w_fall    = ~r_sync2 & r_sync_prev;
  assign w_timeout = (r_idle >= TIMEOUT);

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= S_SYNC;
    else        r_state <= w_state_next;
  end

  // Next-state and per-cycle action decode; an edge wins over a timeout.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    w_state_next = r_state;
    w_start      = 1'b0;
    w_latch      = 1'b0;
    w_publish    = 1'b0;
    w_loss       = 1'b0;
    case (r_state)
      S_SYNC: begin
        if (r_sync_vld[1] && !r_sync2) w_state_next = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (w_rise) begin
          w_start      = 1'b1;
          w_state_next = S_HIGH;
        end else if (w_timeout) begin
          w_loss       = 1'b1;
          w_state_next = S_SYNC;
        end
      end
      S_HIGH: begin
        if (w_fall) begin
          w_latch      = 1'b1;
          w_state_next = S_LOW;
        end else if (w_timeout) begin
          w_loss       = 1'b1;
          w_state_next = S_SYNC;
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_publish    = 1'b1;
          w_state_next = S_HIGH;
        end else if (w_timeout) begin
          w_loss       = 1'b1;
          w_state_next = S_SYNC;
        end
      end
      default: w_state_next = S_SYNC;
    endcase
  end

  // Cycles since the last synchronized edge; held at zero while resyncing.
  always_ff @(posedge CLK) begin
    if (!RESET)                                             r_idle <= '0;
    else if (r_state == S_SYNC || w_rise || w_fall || w_loss) r_idle <= '0;
    else if (r_idle != '1)                                  r_idle <= r_idle + 22'd1;
  end

  // High and period counters (saturating) and the latched width.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_hcnt      <= '0;
      r_pcnt      <= '0;
      r_width_lat <= '0;
    end else if (w_start || w_publish) begin
      r_hcnt <= 21'd1;
      r_pcnt <= 22'd1;
    end else if (r_state == S_HIGH) begin
      if (r_hcnt != '1) r_hcnt <= r_hcnt + 21'd1;
      if (r_pcnt != '1) r_pcnt <= r_pcnt + 22'd1;
      if (w_latch)      r_width_lat <= r_hcnt;
    end else if (r_state == S_LOW) begin
      if (r_pcnt != '1) r_pcnt <= r_pcnt + 22'd1;
    end
  end

  // Published results: measurement on each completed period, loss on timeout.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_width  <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_pos    <= '0;
      r_loss   <= '0;
    end else begin
      r_valid <= w_publish;
      if (w_publish) begin
        r_width  <= r_width_lat;
        r_period <= r_pcnt;
        r_pos    <= classify(r_width_lat);
        r_loss   <= 2'b00;
      end else if (w_loss) begin
        r_pos  <= 3'b000;
        r_loss <= r_sync2 ? 2'b10 : 2'b01;
      end
    end
  end

  assign WIDTH  = r_width;
  assign PERIOD = r_period;
  assign VALID  = r_valid;
  assign POS    = r_pos;
  assign LOSS   = r_loss;

endmodule
